// File: rtl/lvds_tx_serializer.sv
// ---------------------------------------------------------------------------
// lvds_tx_serializer
//
// Frame transmitter for the LVDS VS/CLK/DATA link. The EU side loads 32-bit
// words into an internal dual-port buffer and pulses START. The block then
// divides CLK to make the link clock, sends PRE_BITS bit periods with VS high,
// then the whole buffer MSB-first with VS low, then one bit period with VS
// high again, and finally pulses DONE.
//
// Optional feature (macro LVDS_TX_CONTINUOUS_EN): adds input STOP. Frames then
// repeat back-to-back until STOP has been seen high during the run.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   TX_BUF_WEN   in   buffer write strobe (accepted at any time)
//   TX_BUF_ADDR  in   buffer write address
//   TX_BUF_DATA  in   buffer write data
//   START        in   one-cycle frame request (honoured only when idle)
//   STOP         in   end continuous run (LVDS_TX_CONTINUOUS_EN only)
//   BUSY         out  high from START acceptance until DONE
//   DONE         out  one-CLK pulse at frame end
//   LVDS_VS      out  frame valid, active low
//   LVDS_CLK     out  link clock, idle low
//   LVDS_DATA    out  serial data, changes on LVDS_CLK falling edges only
// ---------------------------------------------------------------------------
module lvds_tx_serializer #(
  parameter int FRAME_WORDS = 512,
  parameter int WORD_W      = 32,
  parameter int CLK_DIV     = 2,
  parameter int PRE_BITS    = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           TX_BUF_WEN,
  input  logic [$clog2(FRAME_WORDS)-1:0] TX_BUF_ADDR,
  input  logic [WORD_W-1:0]              TX_BUF_DATA,
  input  logic                           START,
`ifdef LVDS_TX_CONTINUOUS_EN
  input  logic                           STOP,
`endif
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           LVDS_VS,
  output logic                           LVDS_CLK,
  output logic                           LVDS_DATA
);

  localparam int ADDR_W = $clog2(FRAME_WORDS);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int PH_W   = $clog2(CLK_DIV);
  localparam int PRE_W  = $clog2(PRE_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_SEND, S_POST} state_t;

  logic [WORD_W-1:0] mem [FRAME_WORDS];
  logic [WORD_W-1:0] rd_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [PRE_W-1:0]  pre_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_W-1:0] shreg;

  logic tick, fall_tick, rise_tick, last_bit, last_word, stop_req;

  // The divider only runs outside IDLE, so LVDS_CLK stays low while idle.
  assign tick      = (state != S_IDLE) && (phase == PH_W'(CLK_DIV - 1));
  assign fall_tick = tick &&  LVDS_CLK;
  assign rise_tick = tick && !LVDS_CLK;
  assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_word = (word_cnt == ADDR_W'(FRAME_WORDS - 1));

`ifdef LVDS_TX_CONTINUOUS_EN
  logic stop_seen;

  // Sticky for the whole run; STOP sampled in the final POST cycle counts too.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   stop_seen <= 1'b0;
    else if (state == S_IDLE)  stop_seen <= 1'b0;
    else if (STOP)             stop_seen <= 1'b1;
  end

  assign stop_req = stop_seen | STOP;
`else
  assign stop_req = 1'b1;
`endif

  // Read requests: word 0 at frame start, word n+1 early in word n so the
  // 1-cycle buffer latency never matters at the word boundary.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // paths that skip the assignment infer a latch.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == S_IDLE && START && !DONE) begin
      rd_en = 1'b1;
    end else if (state == S_SEND && bit_cnt == BIT_W'(1)) begin
      rd_en   = 1'b1;
      rd_addr = word_cnt + ADDR_W'(1);
    end else if (state == S_POST && fall_tick && !stop_req) begin
      rd_en = 1'b1;
    end
  end

  // NOTE: the buffer has no reset; frame data must survive RST, and a
  // resettable memory would not map onto block RAM.
  always_ff @(posedge CLK) begin
    if (TX_BUF_WEN) mem[TX_BUF_ADDR] <= TX_BUF_DATA;
    if (rd_en)      rd_data <= mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      phase     <= '0;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shreg     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      LVDS_VS   <= 1'b1;
      LVDS_CLK  <= 1'b0;
      LVDS_DATA <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state != S_IDLE) begin
        phase <= tick ? '0 : phase + PH_W'(1);
        if (tick) LVDS_CLK <= !LVDS_CLK;
      end

      case (state)
        S_IDLE: begin
          // DONE still high means the previous frame is just closing.
          if (START && !DONE) begin
            state    <= S_PRE;
            BUSY     <= 1'b1;
            pre_cnt  <= '0;
            word_cnt <= '0;
          end
        end

        S_PRE: begin
          if (rise_tick) pre_cnt <= pre_cnt + PRE_W'(1);
          if (fall_tick && pre_cnt == PRE_W'(PRE_BITS)) begin
            LVDS_VS   <= 1'b0;
            LVDS_DATA <= rd_data[WORD_W-1];
            shreg     <= rd_data;
            bit_cnt   <= '0;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (fall_tick) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (last_word) begin
                LVDS_VS   <= 1'b1;
                LVDS_DATA <= 1'b0;
                state     <= S_POST;
              end else begin
                word_cnt  <= word_cnt + ADDR_W'(1);
                shreg     <= rd_data;
                LVDS_DATA <= rd_data[WORD_W-1];
              end
            end else begin
              shreg     <= shreg << 1;
              LVDS_DATA <= shreg[WORD_W-2];
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end
          end
        end

        S_POST: begin
          if (fall_tick) begin
            DONE <= 1'b1;
            if (stop_req) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else begin
              state    <= S_PRE;
              pre_cnt  <= '0;
              word_cnt <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_lvds_tx_serializer
//
// Directed bench for lvds_tx_serializer with a 4-word frame and CLK_DIV=2.
// Link activity is observed on CLK falling edges: each LVDS_CLK rise is
// detected there and VS/DATA are recorded for it.
// ---------------------------------------------------------------------------
module tb_lvds_tx_serializer;

  localparam int FW = 4;
  localparam int WW = 32;
  localparam int CD = 2;
  localparam int PB = 4;

  localparam logic [127:0] W_ORIG = {32'hA5A50001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
  localparam logic [127:0] W_MID  = {32'hA5A50001, 32'h80000000, 32'h00000001, 32'hDEADBEEF};
  localparam logic [127:0] W_NEW  = {32'h12345678, 32'h80000000, 32'h00000001, 32'hDEADBEEF};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TX_BUF_WEN = 1'b0;
  logic [1:0]  TX_BUF_ADDR = '0;
  logic [31:0] TX_BUF_DATA = '0;
  logic        START = 1'b0;
`ifdef LVDS_TX_CONTINUOUS_EN
  logic        STOP = 1'b0;
`endif
  logic        BUSY, DONE, LVDS_VS, LVDS_CLK, LVDS_DATA;

  int tests = 0;
  int fails = 0;

  // Results of the last run_frame call.
  int           pre_rises, pay_bits, post_rises, spacing_err, idle_data_err, busy_drop;
  logic         done_seen, busy_at_done;
  logic [127:0] frame_bits;

  lvds_tx_serializer #(
    .FRAME_WORDS(FW), .WORD_W(WW), .CLK_DIV(CD), .PRE_BITS(PB)
  ) dut (
    .CLK(CLK), .RST(RST),
    .TX_BUF_WEN(TX_BUF_WEN), .TX_BUF_ADDR(TX_BUF_ADDR), .TX_BUF_DATA(TX_BUF_DATA),
    .START(START),
`ifdef LVDS_TX_CONTINUOUS_EN
    .STOP(STOP),
`endif
    .BUSY(BUSY), .DONE(DONE),
    .LVDS_VS(LVDS_VS), .LVDS_CLK(LVDS_CLK), .LVDS_DATA(LVDS_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {VS, CLK, DATA, BUSY, DONE} in the idle/reset state is 5'b10000.
  function automatic logic [4:0] outs();
    return {LVDS_VS, LVDS_CLK, LVDS_DATA, BUSY, DONE};
  endfunction

  task automatic write_word(input logic [1:0] a, input logic [31:0] d);
    @(negedge CLK);
    TX_BUF_WEN  = 1'b1;
    TX_BUF_ADDR = a;
    TX_BUF_DATA = d;
    @(negedge CLK);
    TX_BUF_WEN  = 1'b0;
  endtask

  task automatic start_pulse(input string tag);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check($sformatf("%s.busy_after_start", tag), BUSY, 1'b1);
  endtask

  // Observe one frame until DONE (or until stop_bits payload bits have been
  // seen). Optionally re-pulses START every start_period cycles, and rewrites
  // words 0 and 3 while word 1 is on the line.
  task automatic run_frame(input int start_period, input bit do_write, input int stop_bits);
    logic prev_clk;
    int   last_rise;
    int   wr_step;
    pre_rises = 0; pay_bits = 0; post_rises = 0; spacing_err = 0;
    idle_data_err = 0; busy_drop = 0; done_seen = 1'b0; busy_at_done = 1'b1;
    frame_bits = '0; prev_clk = 1'b0; last_rise = -1; wr_step = 0;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      @(negedge CLK);
      if (LVDS_CLK && !prev_clk) begin
        if (last_rise >= 0 && cyc - last_rise != 2 * CD) spacing_err++;
        last_rise = cyc;
        if (!LVDS_VS) begin
          frame_bits = {frame_bits[126:0], LVDS_DATA};
          pay_bits++;
        end else begin
          if (pay_bits == 0) pre_rises++;
          else               post_rises++;
          if (LVDS_DATA) idle_data_err++;
        end
      end
      prev_clk = LVDS_CLK;
      if (DONE) begin
        done_seen    = 1'b1;
        busy_at_done = BUSY;
        break;
      end
      if (!BUSY) busy_drop++;
      if (stop_bits != 0 && pay_bits == stop_bits) break;
      START = (start_period > 0) && (cyc % start_period == 0);
      if (do_write) begin
        TX_BUF_WEN = 1'b0;
        if (wr_step == 0 && pay_bits >= 40) begin
          TX_BUF_WEN = 1'b1; TX_BUF_ADDR = 2'd0; TX_BUF_DATA = 32'h12345678; wr_step = 1;
        end else if (wr_step == 1) begin
          TX_BUF_WEN = 1'b1; TX_BUF_ADDR = 2'd3; TX_BUF_DATA = 32'hDEADBEEF; wr_step = 2;
        end
      end
    end
    START      = 1'b0;
    TX_BUF_WEN = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [127:0] exp);
    check($sformatf("%s.done_seen", tag),    done_seen, 1'b1);
    check($sformatf("%s.pre_rises", tag),    pre_rises, PB);
    check($sformatf("%s.payload_bits", tag), pay_bits, FW * WW);
    check($sformatf("%s.post_rises", tag),   post_rises, 1);
    check($sformatf("%s.rise_spacing", tag), spacing_err, 0);
    check($sformatf("%s.idle_data", tag),    idle_data_err, 0);
    check($sformatf("%s.busy_held", tag),    busy_drop, 0);
    check($sformatf("%s.busy_at_done", tag), busy_at_done, 1'b0);
    check($sformatf("%s.payload", tag),      frame_bits, exp);
  endtask

  initial begin
    // 1: reset held with START high; outputs idle throughout.
    START = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check($sformatf("reset_hold[%0d]", i), outs(), 5'b10000);
    end
    START = 1'b0;
    RST   = 1'b0;
    @(negedge CLK);
    check("after_reset", outs(), 5'b10000);

    write_word(2'd0, 32'hA5A50001);
    write_word(2'd1, 32'h80000000);
    write_word(2'd2, 32'h00000001);
    write_word(2'd3, 32'hFFFFFFFF);

    // 2: basic frame.
    start_pulse("f1");
    run_frame(0, 1'b0, 0);
    check_frame("f1", W_ORIG);
    @(negedge CLK);
    check("f1.done_one_cycle", outs(), 5'b10000);

    // 3: repeated START during a frame, START coincident with DONE ignored,
    // START in the cycle after DONE accepted.
    start_pulse("f2");
    run_frame(50, 1'b0, 0);
    check_frame("f2", W_ORIG);
    START = 1'b1;
    @(negedge CLK);
    check("f2.start_with_done_ignored", BUSY, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    check("f3.start_after_done_taken", BUSY, 1'b1);
    run_frame(0, 1'b0, 0);
    check_frame("f3", W_ORIG);

    // 4: asynchronous reset during word 2 bit 17, then a clean resend.
    start_pulse("f4");
    run_frame(0, 1'b0, 79);
    check("f4.reached_bit17", pay_bits, 79);
    check("f4.mid_frame_active", {LVDS_VS, LVDS_CLK, BUSY}, 3'b011);
    #1 RST = 1'b1;
    #1 check("f4.async_reset", outs(), 5'b10000);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("f4.idle_after_reset", outs(), 5'b10000);
    start_pulse("f5");
    run_frame(0, 1'b0, 0);
    check_frame("f5", W_ORIG);

    // 5: rewrite words 0 and 3 while word 1 is shifting.
    start_pulse("f6");
    run_frame(0, 1'b1, 0);
    check_frame("f6", W_MID);
    start_pulse("f7");
    run_frame(0, 1'b0, 0);
    check_frame("f7", W_NEW);

`ifdef LVDS_TX_CONTINUOUS_EN
    // 6: continuous frames, STOP during frame 3.
    begin
      int dones;
      int since;
      int extra;
      dones = 0; since = 0; extra = 0;
      start_pulse("cont");
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge CLK);
        STOP = 1'b0;
        if (DONE) dones++;
        if (!BUSY) break;
        if (dones == 2) since++;
        if (since == 100) STOP = 1'b1;
      end
      STOP = 1'b0;
      repeat (60) begin
        @(negedge CLK);
        if (DONE) extra++;
      end
      check("cont.done_count", dones, 3);
      check("cont.busy_low", BUSY, 1'b0);
      check("cont.no_extra_done", extra, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
